// File: rtl/drcp_pkg.sv
// Shared constants and types for the fast-GPIO custom-instruction unit:
// funct7 opcodes, sequencer state encoding and the sequencer FIFO entry.
package drcp_pkg;

  localparam int GPIO_W_DEF    = 8;
  localparam int SEQ_DEPTH_DEF = 4;

  localparam logic [6:0] F7_RD_IN     = 7'h00;
  localparam logic [6:0] F7_RD_BIT    = 7'h01;
  localparam logic [6:0] F7_RD_DIR    = 7'h02;
  localparam logic [6:0] F7_SET_DIR   = 7'h10;
  localparam logic [6:0] F7_WR_OUT    = 7'h40;
  localparam logic [6:0] F7_SET       = 7'h41;
  localparam logic [6:0] F7_CLR       = 7'h42;
  localparam logic [6:0] F7_TGL       = 7'h43;
  localparam logic [6:0] F7_SEQ_PUSH  = 7'h60;
  localparam logic [6:0] F7_SEQ_STAT  = 7'h61;
  localparam logic [6:0] F7_SEQ_FLUSH = 7'h62;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_HOLD = 1'b1
  } seq_state_t;

  // value is stored zero-extended; only the low GPIO_W bits reach the pins
  typedef struct packed {
    logic [31:0] value;
    logic [15:0] hold;
  } seq_entry_t;

endpackage

// File: rtl/fgpio_seq_fifo.sv
// Sequencer entry FIFO: synchronous, registered occupancy count, flush has
// priority over push/pop. DEPTH must be a power of two.
module fgpio_seq_fifo
  import drcp_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  seq_entry_t       wdata,
  input  logic             pop,
  input  logic             flush,
  output seq_entry_t       rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  seq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/fgpio_seq.sv
// Fast-GPIO custom-instruction unit with a timed output sequencer.
// Optional macro FGPIO_IN_SYNC_EN inserts a 2-flop input synchronizer.
module fgpio_seq
  import drcp_pkg::*;
#(
  parameter int GPIO_W    = GPIO_W_DEF,
  parameter int SEQ_DEPTH = SEQ_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fgpio_req,
  input  logic [6:0]        fgpio_funct7,
  input  logic [31:0]       fgpio_rs1_val,
  input  logic [31:0]       fgpio_rs2_val,
  output logic              fgpio_ack,
  output logic              fgpio_error,
  output logic [31:0]       fgpio_rd_val,
  output logic [GPIO_W-1:0] gpio_dir,
  input  logic [GPIO_W-1:0] gpio_in_val,
  output logic [GPIO_W-1:0] gpio_out_val
);
  localparam int LVL_W = $clog2(SEQ_DEPTH) + 1;

  logic [GPIO_W-1:0] dir_q, dir_n, out_q, out_n, in_v, rs1_w, rs2_w;
  logic [31:0]       in_ext;
  logic              out_we, push, flush, pop, seq_load, busy, full, empty;
  logic [LVL_W-1:0]  level;
  seq_entry_t        head, wentry;
  seq_state_t        state_q;
  logic [15:0]       cnt_q;
  logic              unused_ok;

`ifdef FGPIO_IN_SYNC_EN
  logic [GPIO_W-1:0] sync_q1, sync_q2;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gpio_in_val;
      sync_q2 <= sync_q1;
    end
  end
  assign in_v = sync_q2;
`else
  assign in_v = gpio_in_val;
`endif

  assign in_ext    = 32'(in_v);
  assign rs1_w     = fgpio_rs1_val[GPIO_W-1:0];
  assign rs2_w     = fgpio_rs2_val[GPIO_W-1:0];
  assign wentry    = '{value: 32'(rs1_w), hold: fgpio_rs2_val[15:0]};
  assign busy      = (state_q == SEQ_HOLD) || (level != '0);
  // last hold cycle chains straight into the next entry, so no gap cycle
  assign seq_load  = !empty && ((state_q == SEQ_IDLE) || (cnt_q == 16'd1));
  assign pop       = seq_load && !flush;
  assign unused_ok = ^{fgpio_rs2_val, head.value};

  fgpio_seq_fifo #(.DEPTH(SEQ_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    fgpio_ack    = 1'b0;
    fgpio_error  = 1'b0;
    fgpio_rd_val = '0;
    dir_n        = dir_q;
    out_n        = out_q;
    out_we       = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;
    if (fgpio_req && !rst_i) begin
      fgpio_ack = 1'b1;
      case (fgpio_funct7)
        F7_RD_IN:  fgpio_rd_val = in_ext;
        F7_RD_BIT: begin
          if (fgpio_rs1_val >= 32'(GPIO_W)) fgpio_error = 1'b1;
          else fgpio_rd_val = {31'b0, in_ext[fgpio_rs1_val[4:0]]};
        end
        F7_RD_DIR:  fgpio_rd_val = 32'(dir_q);
        F7_SET_DIR: dir_n = (dir_q & ~rs2_w) | (rs1_w & rs2_w);
        F7_WR_OUT, F7_SET, F7_CLR, F7_TGL: begin
          // the sequencer owns the pins while it has work
          if (busy) fgpio_error = 1'b1;
          else begin
            out_we = 1'b1;
            case (fgpio_funct7)
              F7_WR_OUT: out_n = (out_q & ~rs2_w) | (rs1_w & rs2_w);
              F7_SET:    out_n = out_q | rs1_w;
              F7_CLR:    out_n = out_q & ~rs1_w;
              default:   out_n = out_q ^ rs1_w;
            endcase
          end
        end
        F7_SEQ_PUSH: begin
          if (full) fgpio_ack = 1'b0;
          else push = 1'b1;
        end
        F7_SEQ_STAT:  fgpio_rd_val = {23'b0, 8'(level), busy};
        F7_SEQ_FLUSH: flush = 1'b1;
        default:      fgpio_error = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q   <= '0;
      out_q   <= '0;
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      dir_q <= dir_n;
      if (out_we) out_q <= out_n;
      if (flush) begin
        state_q <= SEQ_IDLE;
        cnt_q   <= '0;
      end else if (seq_load) begin
        state_q <= SEQ_HOLD;
        cnt_q   <= (head.hold == 16'd0) ? 16'd1 : head.hold;
        out_q   <= head.value[GPIO_W-1:0];
      end else if (state_q == SEQ_HOLD) begin
        if (cnt_q == 16'd1) state_q <= SEQ_IDLE;
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  assign gpio_dir     = dir_q;
  assign gpio_out_val = out_q;

endmodule

// File: tb/tb_fgpio_seq.sv
// Directed self-checking bench for fgpio_seq (GPIO_W=8, SEQ_DEPTH=4, no input sync).
module tb_fgpio_seq;
  localparam logic [6:0] RD_IN = 7'h00, RD_BIT = 7'h01, RD_DIR = 7'h02, SET_DIR = 7'h10;
  localparam logic [6:0] WR_OUT = 7'h40, SET = 7'h41, CLR = 7'h42, TGL = 7'h43;
  localparam logic [6:0] PUSH = 7'h60, STAT = 7'h61, FLUSH = 7'h62;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [6:0]  f7 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        ack, err;
  logic [31:0] rd;
  logic [7:0]  dir, gin = '0, gout;

  int n_pass = 0, n_total = 0, cyc = 0;
  logic        e;
  logic [31:0] r;
  int          w;

  fgpio_seq #(.GPIO_W(8), .SEQ_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .fgpio_req(req), .fgpio_funct7(f7),
    .fgpio_rs1_val(rs1), .fgpio_rs2_val(rs2), .fgpio_ack(ack), .fgpio_error(err),
    .fgpio_rd_val(rd), .gpio_dir(dir), .gpio_in_val(gin), .gpio_out_val(gout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request at posedge+1, hold it until ack; returns at posedge+1 after the ack cycle.
  task automatic do_op(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic eo, output logic [31:0] ro, output int waits);
    req = 1'b1; f7 = f; rs1 = a; rs2 = b; waits = 0;
    @(negedge clk);
    while (!ack && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    eo = err; ro = rd;
    if (!ack) begin
      n_total++;
      $display("FAIL ack_timeout: funct7=%h got ack=0 after %0d cycles, expected ack=1", f, waits);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset();
    req = 1'b1; f7 = RD_DIR;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (ack !== 1'b0 || err !== 1'b0 || rd !== 32'h0) $display("FAIL reset_resp: got ack=%b err=%b rd=%h expected 0/0/0", ack, err, rd); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    n_total++; if (dir !== 8'h00 || gout !== 8'h00) $display("FAIL reset_regs: got dir=%h out=%h expected 00/00", dir, gout); else n_pass++;
    do_op(RD_DIR, 0, 0, e, r, w);
    n_total++; if (r !== 32'h0 || e !== 1'b0) $display("FAIL rd_dir_reset: got rd=%h err=%b expected 0/0", r, e); else n_pass++;
  endtask

  task automatic test_dir();
    do_op(SET_DIR, 32'hF0, 32'hFF, e, r, w);
    n_total++; if (dir !== 8'hF0 || e !== 1'b0) $display("FAIL set_dir1: got dir=%h err=%b expected F0/0", dir, e); else n_pass++;
    do_op(SET_DIR, 32'h00, 32'h30, e, r, w);
    n_total++; if (dir !== 8'hC0) $display("FAIL set_dir2: got dir=%h expected C0", dir); else n_pass++;
    do_op(RD_DIR, 0, 0, e, r, w);
    n_total++; if (r !== 32'hC0) $display("FAIL rd_dir: got %h expected 000000C0", r); else n_pass++;
  endtask

  task automatic test_read();
    gin = 8'h5A;
    do_op(RD_IN, 0, 0, e, r, w);
    n_total++; if (r !== 32'h5A || e !== 1'b0) $display("FAIL rd_in: got rd=%h err=%b expected 5A/0", r, e); else n_pass++;
    do_op(RD_BIT, 1, 0, e, r, w);
    n_total++; if (r !== 32'h1 || e !== 1'b0) $display("FAIL rd_bit1: got rd=%h err=%b expected 1/0", r, e); else n_pass++;
    do_op(RD_BIT, 7, 0, e, r, w);
    n_total++; if (r !== 32'h0 || e !== 1'b0) $display("FAIL rd_bit7: got rd=%h err=%b expected 0/0", r, e); else n_pass++;
    do_op(RD_BIT, 9, 0, e, r, w);
    n_total++; if (r !== 32'h0 || e !== 1'b1) $display("FAIL rd_bit9: got rd=%h err=%b expected 0/1", r, e); else n_pass++;
    do_op(RD_BIT, 8, 0, e, r, w);
    n_total++; if (r !== 32'h0 || e !== 1'b1) $display("FAIL rd_bit8: got rd=%h err=%b expected 0/1", r, e); else n_pass++;
  endtask

  task automatic test_bitops();
    do_op(SET, 32'h0F, 0, e, r, w);
    n_total++; if (gout !== 8'h0F || e !== 1'b0) $display("FAIL set: got out=%h err=%b expected 0F/0", gout, e); else n_pass++;
    do_op(TGL, 32'h03, 0, e, r, w);
    n_total++; if (gout !== 8'h0C) $display("FAIL tgl: got out=%h expected 0C", gout); else n_pass++;
    do_op(CLR, 32'h04, 0, e, r, w);
    n_total++; if (gout !== 8'h08) $display("FAIL clr: got out=%h expected 08", gout); else n_pass++;
    do_op(WR_OUT, 32'hFFFF_FFA0, 32'h0000_00F0, e, r, w);
    n_total++; if (gout !== 8'hA8) $display("FAIL wr_out: got out=%h expected A8", gout); else n_pass++;
    do_op(7'h7F, 32'hFF, 32'hFF, e, r, w);
    n_total++; if (e !== 1'b1 || gout !== 8'hA8 || dir !== 8'hC0) $display("FAIL unknown_op: got err=%b out=%h dir=%h expected 1/A8/C0", e, gout, dir); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [7:0] exp;
    do_op(PUSH, 32'hAA, 32'd3, e, r, w);   // acked in cycle T
    n_total++; if (w !== 0 || gout !== 8'hA8) $display("FAIL seq_push1: got waits=%0d out=%h expected 0/A8", w, gout); else n_pass++;
    do_op(PUSH, 32'h55, 32'd0, e, r, w);
    for (int k = 2; k <= 7; k++) begin
      exp = (k <= 4) ? 8'hAA : 8'h55;
      n_total++; if (gout !== exp) $display("FAIL seq_out_T+%0d: got %h expected %h", k, gout, exp); else n_pass++;
      @(posedge clk); #1;
    end
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h0) $display("FAIL seq_stat_done: got %h expected 0", r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0, d;
    logic [7:0] exp;
    t0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      do_op(PUSH, k, 32'd10, e, r, w);
      n_total++; if (w !== 0) $display("FAIL bp_push%0d_waits: got %0d expected 0", k, w); else n_pass++;
      if (k >= 2) begin
        n_total++; if (gout !== 8'h01) $display("FAIL bp_out_T+%0d: got %h expected 01", k, gout); else n_pass++;
      end
    end
    do_op(PUSH, 6, 32'd10, e, r, w);
    n_total++; if (w !== 7) $display("FAIL bp_push6_stall: got %0d wait cycles expected 7", w); else n_pass++;
    while (cyc - t0 <= 63) begin
      d = cyc - t0;
      exp = (d >= 62) ? 8'd6 : 8'((d - 2) / 10 + 1);
      n_total++; if (gout !== exp) $display("FAIL bp_out_T+%0d: got %h expected %h", d, gout, exp); else n_pass++;
      @(posedge clk); #1;
    end
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h0) $display("FAIL bp_stat_done: got %h expected 0", r); else n_pass++;
  endtask

  task automatic test_busy_errors();
    do_op(PUSH, 32'hAA, 32'd5, e, r, w);
    do_op(PUSH, 32'hBB, 32'd5, e, r, w);
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h3) $display("FAIL busy_stat: got %h expected 3", r); else n_pass++;
    do_op(WR_OUT, 32'h00, 32'hFF, e, r, w);
    n_total++; if (e !== 1'b1 || gout !== 8'hAA) $display("FAIL wr_out_busy: got err=%b out=%h expected 1/AA", e, gout); else n_pass++;
    do_op(SET, 32'h01, 0, e, r, w);
    n_total++; if (e !== 1'b1 || gout !== 8'hAA) $display("FAIL set_busy: got err=%b out=%h expected 1/AA", e, gout); else n_pass++;
    do_op(FLUSH, 0, 0, e, r, w);
    n_total++; if (e !== 1'b0 || gout !== 8'hAA) $display("FAIL flush: got err=%b out=%h expected 0/AA", e, gout); else n_pass++;
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h0) $display("FAIL flush_stat: got %h expected 0", r); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++; if (gout !== 8'hAA) $display("FAIL flush_hold_%0d: got %h expected AA", k, gout); else n_pass++;
      @(posedge clk); #1;
    end
    do_op(FLUSH, 0, 0, e, r, w);
    n_total++; if (e !== 1'b0 || gout !== 8'hAA) $display("FAIL flush_idle: got err=%b out=%h expected 0/AA", e, gout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_op(PUSH, 32'h11, 32'd10, e, r, w);
    do_op(PUSH, 32'h22, 32'd10, e, r, w);
    do_op(PUSH, 32'h33, 32'd10, e, r, w);
    do_op(PUSH, 32'h44, 32'd10, e, r, w);
    do_op(SET_DIR, 32'h0F, 32'h0F, e, r, w);
    n_total++; if (e !== 1'b0 || dir !== 8'hCF || gout !== 8'h11) $display("FAIL dir_busy: got err=%b dir=%h out=%h expected 0/CF/11", e, dir, gout); else n_pass++;
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h7) $display("FAIL stat_3q: got %h expected 7", r); else n_pass++;
    rst = 1'b1; req = 1'b1; f7 = PUSH; rs1 = 32'h99; rs2 = 32'd1;
    @(negedge clk);
    n_total++; if (ack !== 1'b0 || err !== 1'b0 || rd !== 32'h0) $display("FAIL rst_mid_resp: got ack=%b err=%b rd=%h expected 0/0/0", ack, err, rd); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    n_total++; if (gout !== 8'h00 || dir !== 8'h00) $display("FAIL rst_mid_regs: got out=%h dir=%h expected 00/00", gout, dir); else n_pass++;
    do_op(STAT, 0, 0, e, r, w);
    n_total++; if (r !== 32'h0) $display("FAIL rst_mid_stat: got %h expected 0", r); else n_pass++;
    for (int k = 0; k < 30; k++) begin
      n_total++; if (gout !== 8'h00) $display("FAIL rst_mid_quiet_%0d: got %h expected 00", k, gout); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_dir();
    test_read();
    test_bitops();
    test_sequence();
    test_back_to_back();
    test_busy_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fgpio_seq.md
FGPIO_SEQ -- requirements
Module: fgpio_seq

Interface
REQ-001 SHALL have parameter GPIO_W, default 8, number of GPIO pins (1..32).
REQ-002 SHALL have parameter SEQ_DEPTH, default 4, sequencer FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports fgpio_req input 1; fgpio_funct7 input 7; fgpio_rs1_val input 32; fgpio_rs2_val input 32. These carry the custom-instruction request.
REQ-006 SHALL have ports fgpio_ack output 1; fgpio_error output 1; fgpio_rd_val output 32. These carry the response.
REQ-007 SHALL have ports gpio_dir output GPIO_W (1=output); gpio_in_val input GPIO_W; gpio_out_val output GPIO_W.

Function
REQ-008 Handshake: req held high until ack. ack is combinational in the same cycle for all ops except a stalled push. error and rd_val are valid only while ack=1, otherwise 0.
REQ-009 Funct7 map:
- 0x00 RD_IN: rd = zero-extended input.
- 0x01 RD_BIT: rd = input[rs1].
- 0x02 RD_DIR: rd = dir.
- 0x10 SET_DIR: dir <= (dir & ~rs2) | (rs1 & rs2).
- 0x40 WR_OUT: out <= (out & ~rs2) | (rs1 & rs2).
- 0x41 SET: out |= rs1.
- 0x42 CLR: out &= ~rs1.
- 0x43 TGL: out ^= rs1.
- 0x60 SEQ_PUSH.
- 0x61 SEQ_STAT: rd = {level, busy}, level in bits [8:1], busy in bit 0.
- 0x62 SEQ_FLUSH.
REQ-010 Register writes SHALL be visible on gpio_dir/gpio_out_val the cycle after ack. Operands SHALL be truncated to GPIO_W.
REQ-011 RD_BIT with rs1 >= GPIO_W SHALL give ack, error=1, rd=0.
REQ-012 Unknown funct7 SHALL give ack, error=1, no state change.
REQ-013 SEQ_PUSH SHALL enqueue {value=rs1[GPIO_W-1:0], hold=rs2[15:0]}.
REQ-014 If the registered count equals SEQ_DEPTH, SEQ_PUSH SHALL stall with ack=0. This holds even when a pop occurs in the same cycle. ack SHALL rise in the first cycle the count is below SEQ_DEPTH.
REQ-015 Sequencer SHALL have states IDLE and HOLD.
- IDLE and FIFO non-empty: pop, out <= value next cycle, cnt <= max(hold,1), go to HOLD.
- HOLD: cnt decrements each cycle.
- At cnt==1 with FIFO non-empty: pop next entry back-to-back, no gap cycle.
- At cnt==1 with FIFO empty: go to IDLE; out keeps the last value.
REQ-016 Entry timing: an entry pushed with ack at cycle T into an empty, idle sequencer SHALL appear on gpio_out_val at T+2 and last exactly max(hold,1) cycles.
REQ-017 busy SHALL equal (state==HOLD) | (count != 0).
REQ-018 WR_OUT/SET/CLR/TGL while busy SHALL give ack, error=1, out unchanged. SET_DIR is allowed while busy.
REQ-019 SEQ_FLUSH SHALL empty the FIFO and force IDLE on the next cycle. out keeps its current value. Flush while idle is a no-op with error=0.

Reset
REQ-020 rst_i high at a clock edge SHALL set dir=0, out=0, FIFO empty, state=IDLE, cnt=0.
REQ-021 While rst_i is high, ack, error and rd_val SHALL be 0 and requests are ignored. This applies mid-sequence and mid-stall.

Configuration
REQ-022 With FGPIO_IN_SYNC_EN defined, gpio_in_val SHALL pass through a 2-flop synchronizer (reset 0), so reads reflect the pin 2 cycles late.
REQ-023 Without FGPIO_IN_SYNC_EN, reads SHALL use gpio_in_val combinationally.

Structure
REQ-024 DRCP_PKG SHALL hold the funct7 opcode constants, the sequencer state enum (IDLE/HOLD), the FIFO entry struct, and the GPIO_W/SEQ_DEPTH defaults.
REQ-025 The FIFO SHALL be a sub-module fgpio_seq_fifo: synchronous, registered count, push/pop/flush/full/empty/level.

Verification (GPIO_W=8, SEQ_DEPTH=4, macro off)
REQ-026 After reset:
- RD_DIR -> rd=0x00.
- SET_DIR rs1=0xF0, rs2=0xFF -> gpio_dir=0xF0 next cycle.
- SET_DIR rs1=0x00, rs2=0x30 -> gpio_dir=0xC0.
REQ-027 Bit ops:
- SET rs1=0x0F -> out=0x0F.
- TGL rs1=0x03 -> out=0x0C.
- CLR rs1=0x04 -> out=0x08.
- WR_OUT rs1=0xA0, rs2=0xF0 -> out=0xA8.
REQ-028 Sequence:
- Push (0xAA, hold 3) at T, then (0x55, hold 0).
- Expected out: 0xAA during T+2..T+4, 0x55 at T+5, then 0x55 held.
- SEQ_STAT afterwards -> busy=0, level=0.
REQ-029 Backpressure:
- Six pushes with hold=10 each.
- Pushes 1-5 acked immediately.
- Push 6 ack withheld until entry 2 pops, i.e. the cycle after entry 1's 10th hold cycle.
- Output sequence has no gap cycles.
REQ-030 Errors:
- RD_BIT rs1=9 -> error=1, rd=0.
- funct7=0x7F -> error=1.
- WR_OUT during an active sequence -> error=1, out unchanged.
- SEQ_FLUSH mid-entry -> IDLE next cycle, out holds.
REQ-031 Reset mid-sequence with 3 entries queued SHALL give out=0, level=0, busy=0 the cycle after rst_i, and no further output changes.
